pipe_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32 pipeline. Drives write-enables and bubble (flush) strobes
//  for PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Resolves load-use hazards, taken-branch squash, data-memory

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/pipe_hazard_detect.sv | 21 ++
 rtl/pipe_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        RUN     = 2'd1,
        MEMWAIT = 2'd2,
        ERROR   = 2'd3
    } state_t;

    // x0 is hardwired zero, so a write to it can never create a hazard
    localparam logic [4:0] REG_X0 = 5'd0;

    // Width needed to hold a memory-wait timer that counts up to timeout
    function automatic int timer_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the
// instruction in ID forces one bubble.
import pipe_ctrl_pkg::*;

module pipe_hazard_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    output logic       load_use
);

    logic hit_rs1, hit_rs2;

    assign hit_rs1  = id_use_rs1 && (id_rs1 == ex_rd);
    assign hit_rs2  = id_use_rs2 && (id_rs2 == ex_rd);
    assign load_use = ex_memread && (ex_rd != REG_X0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32 pipeline.
// Optional feature: define PIPE_PERF_EN to build the stall/flush perf
// counters; otherwise stall_cnt/flush_cnt are tied to zero.
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             mem_branch_taken,
    input  logic             mem_req,
    input  logic             dmem_ack,
    output logic             pcwrite,
    output logic             fdwrite,
    output logic             de_en,
    output logic             em_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             em_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int TMR_W = timer_w(MEM_TIMEOUT);
    localparam int CLR_W = $clog2(FLUSH_CYCLES + 1);

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [CLR_W-1:0] clr_cnt;
    logic             load_use;
    logic             advance;

    pipe_hazard_detect u_hazard (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .load_use   (load_use)
    );

    // Output decode from current state and this cycle's hazard inputs
    always_comb begin
        pcwrite  = 1'b0;
        fdwrite  = 1'b0;
        de_en    = 1'b0;
        em_en    = 1'b0;
        mw_en    = 1'b0;
        fd_flush = 1'b0;
        de_flush = 1'b0;
        em_flush = 1'b0;
        advance  = 1'b0;
        case (state)
            CLEAR: begin
                fd_flush = 1'b1;
                de_flush = 1'b1;
                em_flush = 1'b1;
            end
            // An access acked in the same cycle it is issued costs nothing
            RUN:     advance = !(mem_req && !dmem_ack);
            // The ack cycle resumes normal hazard handling immediately
            MEMWAIT: advance = dmem_ack;
            default: advance = 1'b0;
        endcase
        if (advance) begin
            if (mem_branch_taken) begin
                // Squash the three younger instructions behind the branch
                pcwrite  = 1'b1;
                fdwrite  = 1'b1;
                de_en    = 1'b1;
                em_en    = 1'b1;
                mw_en    = 1'b1;
                fd_flush = 1'b1;
                de_flush = 1'b1;
                em_flush = 1'b1;
            end else if (load_use) begin
                // Hold PC and IF/ID, push one bubble into ID/EX
                de_en    = 1'b1;
                em_en    = 1'b1;
                mw_en    = 1'b1;
                de_flush = 1'b1;
            end else begin
                pcwrite  = 1'b1;
                fdwrite  = 1'b1;
                de_en    = 1'b1;
                em_en    = 1'b1;
                mw_en    = 1'b1;
            end
        end
    end

    assign mem_err = (state == ERROR);

    // Sequencer: post-reset clearing, memory wait with timeout, sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            timer   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_cnt == CLR_W'(FLUSH_CYCLES - 1)) state <= RUN;
                    else clr_cnt <= clr_cnt + 1'b1;
                end
                RUN: begin
                    if (!advance) begin
                        state <= MEMWAIT;
                        timer <= TMR_W'(1);
                    end
                end
                MEMWAIT: begin
                    // timer holds the number of frozen cycles so far; the
                    // MEM_TIMEOUT-th unanswered cycle trips the error
                    if (dmem_ack) begin
                        state <= RUN;
                    end else begin
                        timer <= timer + 1'b1;
                        if (timer == TMR_W'(MEM_TIMEOUT - 1)) state <= ERROR;
                    end
                end
                default: state <= ERROR;
            endcase
        end
    end

`ifdef PIPE_PERF_EN
    logic run_like;
    assign run_like = (state == RUN) || (state == MEMWAIT);

    // Perf counters: stalled-PC cycles and taken-branch squashes, free-running wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (run_like && !pcwrite)        stall_cnt <= stall_cnt + 1'b1;
            if (advance && mem_branch_taken) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// traffic, all checked every cycle against a cycle-count reference model.
module tb_pipe_ctrl;

    localparam int FLUSH_CYCLES = 2;
    localparam int MEM_TIMEOUT  = 64;
    localparam int CNT_W        = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic             id_use_rs1 = 0, id_use_rs2 = 0, ex_memread = 0;
    logic             mem_branch_taken = 0, mem_req = 0, dmem_ack = 0;
    logic             pcwrite, fdwrite, de_en, em_en, mw_en;
    logic             fd_flush, de_flush, em_flush, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int compared = 0;
    int mismatched = 0;

    // Reference model state, expressed as cycle counts
    int          clr_left;
    int          waited;
    bit          err;
    logic [31:0] stall_m, flush_m;

    pipe_ctrl #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .MEM_TIMEOUT  (MEM_TIMEOUT),
        .CNT_W        (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_use_rs1       (id_use_rs1),
        .id_use_rs2       (id_use_rs2),
        .ex_memread       (ex_memread),
        .ex_rd            (ex_rd),
        .mem_branch_taken (mem_branch_taken),
        .mem_req          (mem_req),
        .dmem_ack         (dmem_ack),
        .pcwrite          (pcwrite),
        .fdwrite          (fdwrite),
        .de_en            (de_en),
        .em_en            (em_en),
        .mw_en            (mw_en),
        .fd_flush         (fd_flush),
        .de_flush         (de_flush),
        .em_flush         (em_flush),
        .mem_err          (mem_err),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_memread = 0; ex_rd = 0; mem_branch_taken = 0; mem_req = 0; dmem_ack = 0;
    endtask

    // Check one cycle mid-period against the model, then advance the model
    // and the clock. Vector: {pc,fd,de,em,mw en | fd,de,em flush | err}.
    task automatic tick(input string tag);
        logic [8:0]  exp, act;
        logic [31:0] exp_s, exp_f;
        bit          hz, frozen;
        #3;
        hz = ex_memread && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        frozen = 0;
        if (rst || clr_left > 0)                        exp = 9'b00000_111_0;
        else if (err)                                   exp = 9'b00000_000_1;
        else if ((waited > 0 || mem_req) && !dmem_ack) begin
            exp = 9'b00000_000_0; frozen = 1;
        end
        else if (mem_branch_taken)                      exp = 9'b11111_111_0;
        else if (hz)                                    exp = 9'b00111_010_0;
        else                                            exp = 9'b11111_000_0;
        act = {pcwrite, fdwrite, de_en, em_en, mw_en, fd_flush, de_flush, em_flush, mem_err};
        compared++;
        assert (act === exp) else begin
            mismatched++;
            $error("FAIL %s ctl: got %b expected %b", tag, act, exp);
        end
`ifdef PIPE_PERF_EN
        exp_s = stall_m; exp_f = flush_m;
`else
        exp_s = 0; exp_f = 0;
`endif
        compared++;
        assert ({stall_cnt, flush_cnt} === {exp_s, exp_f}) else begin
            mismatched++;
            $error("FAIL %s cnt: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   tag, stall_cnt, flush_cnt, exp_s, exp_f);
        end
        if (rst) begin
            clr_left = FLUSH_CYCLES; waited = 0; err = 0; stall_m = 0; flush_m = 0;
        end else if (clr_left > 0) begin
            clr_left--;
        end else if (!err) begin
            if (frozen) begin
                waited++;
                stall_m++;
                if (waited == MEM_TIMEOUT) err = 1;
            end else begin
                waited = 0;
                if (!exp[8]) stall_m++;
                if (mem_branch_taken) flush_m++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr_left = FLUSH_CYCLES; waited = 0; err = 0; stall_m = 0; flush_m = 0;
        idle();
        @(posedge clk); #1;

        // Reset held, then released: two flush cycles then normal flow
        tick("reset0");
        tick("reset1");
        rst = 0;
        tick("clear0");
        tick("clear1");
        tick("run0");

        // Load-use on rs2: one bubble, then normal
        ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        tick("loaduse");
        idle();
        tick("after_lu");

        // x0 destination is never a hazard
        ex_memread = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        tick("x0");
        idle();

        // Branch wins over a simultaneous load-use
        ex_memread = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1; mem_branch_taken = 1;
        tick("br_lu");
        idle();

        // Zero-cycle memory access
        mem_req = 1; dmem_ack = 1;
        tick("mem0");
        idle();

        // Three wait cycles, advance on the ack cycle
        mem_req = 1;
        tick("mw1"); tick("mw2"); tick("mw3");
        dmem_ack = 1;
        tick("mw_ack");
        idle();
        tick("mw_post");

        // Timeout: error after MEM_TIMEOUT frozen cycles, sticky until reset
        mem_req = 1;
        for (int i = 0; i < MEM_TIMEOUT + 4; i++) tick("timeout");
        dmem_ack = 1;
        tick("err_ack");
        idle();
        rst = 1; tick("err_rst");
        rst = 0; tick("c0"); tick("c1");

        // Reset in the middle of a memory wait
        mem_req = 1;
        tick("mwr1"); tick("mwr2");
        rst = 1; tick("mwr_rst");
        rst = 0; idle();
        tick("c2"); tick("c3"); tick("run1");

        // Random traffic with narrow register indices to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            id_rs1           = 5'($urandom_range(0, 3));
            id_rs2           = 5'($urandom_range(0, 3));
            ex_rd            = 5'($urandom_range(0, 3));
            id_use_rs1       = 1'($urandom_range(0, 1));
            id_use_rs2       = 1'($urandom_range(0, 1));
            ex_memread       = ($urandom_range(0, 2) == 0);
            mem_branch_taken = ($urandom_range(0, 5) == 0);
            mem_req          = ($urandom_range(0, 3) == 0);
            dmem_ack         = ($urandom_range(0, 5) == 0);
            rst              = ($urandom_range(0, 399) == 0);
            tick("rand");
        end
        rst = 0;
        idle();
        tick("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
